sprite_motion_ctrl: RTL and testbench
=====================================

# sprite_motion_ctrl

Parametrised sprite position and pixel-colour controller for the 640x480 VGA path. It moves a SPRITE_W x SPRITE_H sprite under button control, with diagonal motion, hold-to-accelerate, and wrap or clamp at the screen edges. It also tracks facing direction, generates mirrored sprite-ROM addresses, and composites the sprite over a button-selected background. It sits between the button debouncers / display_controller and the VGA output register.

## Interface
Parameters:
- SPRITE_W, 30: sprite width in pixels.
- SPRITE_H, 30: sprite height in pixels.
- X_MIN, 144: first visible hCount.
- X_MAX, 783: last visible hCount.
- Y_MIN, 35: first visible vCount.
- Y_MAX, 515: last visible vCount.
- X_RESET, 450: reset xpos (sprite top-left).
- Y_RESET, 250: reset ypos (sprite top-left).
- SPEED_MIN, 2: pixels per move_tick before the ramp.
- SPEED_MAX, 6: pixels per move_tick after the ramp.
- RAMP_TICKS, 16: held ticks needed to reach FAST.
- WRAP, 1: edge mode; 1 = wrap, 0 = clamp.
- TRANSPARENT, 12'h4F0: sprite colour treated as see-through.

Ports:
- clk, in, 1: single clock (pixel clock).
- rst, in, 1: asynchronous, active-high reset.
- move_tick, in, 1: one-cycle strobe; the position updates only on this strobe.
- up, down, left, right, in, 1 each: debounced button levels.
- bright, in, 1: display-area flag aligned with hCount/vCount.
- hCount, vCount, in, 10 each: scan position.
- sprite_color, in, 12: ROM data, valid one cycle after rom_row/rom_col.
- rom_row, rom_col, out, 10 each: registered sprite-ROM address.
- xpos, ypos, out, 10 each: current sprite top-left position.
- facing_left, out, 1: sprite orientation.
- rgb, out, 12: pixel colour.
- background, out, 12: current background colour.

## Operation
- Legal position range: xpos in [X_MIN, XL], where XL = X_MAX-SPRITE_W+1; ypos in [Y_MIN, YL], where YL = Y_MAX-SPRITE_H+1.
- Position arithmetic uses 11-bit signed intermediates, so there is no unsigned underflow.
- Axis resolution is sampled only on move_tick:
  - dx = right - left; dy = down - up.
  - Opposite buttons on one axis cancel on that axis.
  - Both axes may move on the same tick (diagonal).
- Step FSM, with hold counter hc of width clog2(RAMP_TICKS)+1:
  - IDLE: step = 0, hc = 0. On a tick with any button pressed, go to SLOW.
  - SLOW: step = SPEED_MIN; hc increments each tick. On a tick with hc == RAMP_TICKS-1 and a button pressed, go to FAST.
  - FAST: step = SPEED_MAX.
  - From SLOW or FAST, a tick with all buttons released goes to IDLE and clears hc.
  - The first tick of a press moves by SPEED_MIN. The FSM state is the one used for the step.
- Edges:
  - WRAP=1: a step that would exceed XL sets xpos = X_MIN; a step that would go below X_MIN sets xpos = XL. Y behaves identically.
  - WRAP=0: saturate at the limits.
- facing_left:
  - Set on a tick with dx < 0; cleared on a tick with dx > 0; otherwise held.
- background: updates every cycle (not gated by tick), priority right > left > down > up, held when no button is pressed.
  - right: 12'hFF0.
  - left: 12'h0FF.
  - down: 12'h0F0.
  - up: 12'h00F.
- Pixel pipeline:
  - Stage 1 registers:
    - fill1 = hCount in [xpos, xpos+SPRITE_W-1] and vCount in [ypos, ypos+SPRITE_H-1].
    - rom_row = vCount-ypos.
    - rom_col = facing_left ? SPRITE_W-1-(hCount-xpos) : hCount-xpos.
    - bright1 = bright.
  - Stage 2 output:
    - rgb = 0 if !bright2.
    - Otherwise rgb = sprite_color if fill2 and sprite_color != TRANSPARENT.
    - Otherwise rgb = background.
- Reset values:
  - xpos = X_RESET, ypos = Y_RESET, facing_left = 0.
  - FSM = IDLE, hc = 0.
  - background = 12'hFFF.
  - rgb, rom_row and rom_col = 0; pipeline flags = 0.

## Timing
- Position and facing_left update on the clock edge where move_tick = 1. They are stable on all other cycles.
- rgb lags hCount/vCount/bright by 2 cycles. The display timing must delay hsync/vsync by 2 to match.
- rom_row/rom_col lag hCount/vCount by 1 cycle.
- xpos/ypos changing mid-frame is permitted. Fill uses the values present at stage 1.
- Reset asserted mid-ramp returns the block to IDLE immediately. The first tick after release moves by SPEED_MIN.

## Configuration
- SPRITE_MOTION_RAMP_EN defined: the full IDLE/SLOW/FAST ramp operates.
- SPRITE_MOTION_RAMP_EN undefined:
  - FAST and hc are removed.
  - Step is always SPEED_MIN while any button is pressed.
  - RAMP_TICKS and SPEED_MAX are ignored.

## Test plan
- Reset, then right held for 20 ticks (defaults, RAMP_EN):
  - Ticks 1-16 step by 2.
  - Ticks 17-20 step by 6.
  - Final xpos = 450+32+24 = 506.
- WRAP=1, xpos = 754 (XL), right held on a tick -> xpos = 144.
- WRAP=1, xpos = 144, left held on a tick -> xpos = 754, facing_left = 1.
- WRAP=0, ypos = 36, up held on a tick -> ypos = 35; another tick -> ypos stays 35.
- up+right held on a tick -> xpos+2 and ypos-2. left+right held -> xpos unchanged, facing_left unchanged.
- facing_left = 1, hCount = xpos, bright = 1 -> rom_col = 29 one cycle later. With sprite_color = 12'h4F0, rgb = background two cycles later; with sprite_color = 12'hF00, rgb = 12'hF00.

Source files
------------

// File: rtl/sprite_motion_if.sv
// sprite_motion_if
//   Groups the button, scan and pixel signals of sprite_motion_ctrl.
//   master: the surrounding display path (drives buttons, scan position,
//           ROM data; receives position, ROM address and pixel colour).
//   slave : sprite_motion_ctrl itself.
//   Signals:
//     move_tick            1   position update strobe
//     up/down/left/right   1   debounced button levels
//     bright               1   display-area flag aligned with hCount/vCount
//     hCount, vCount       10  scan position
//     sprite_color         12  sprite ROM data
//     rom_row, rom_col     10  registered sprite ROM address
//     xpos, ypos           10  sprite top-left position
//     facing_left          1   sprite orientation
//     rgb                  12  composited pixel colour
//     background           12  current background colour
interface sprite_motion_if;
    logic        move_tick;
    logic        up;
    logic        down;
    logic        left;
    logic        right;
    logic        bright;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic [11:0] sprite_color;
    logic [9:0]  rom_row;
    logic [9:0]  rom_col;
    logic [9:0]  xpos;
    logic [9:0]  ypos;
    logic        facing_left;
    logic [11:0] rgb;
    logic [11:0] background;

    modport master (
        output move_tick, up, down, left, right, bright, hCount, vCount, sprite_color,
        input  rom_row, rom_col, xpos, ypos, facing_left, rgb, background
    );

    modport slave (
        input  move_tick, up, down, left, right, bright, hCount, vCount, sprite_color,
        output rom_row, rom_col, xpos, ypos, facing_left, rgb, background
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
//   Moves a SPRITE_W x SPRITE_H sprite under button control (diagonal
//   motion, hold-to-accelerate, wrap or clamp at the screen edges), tracks
//   facing direction, generates mirrored sprite ROM addresses and composites
//   the sprite over a button-selected background.
//   Ports:
//     clk  pixel clock
//     rst  asynchronous active-high reset
//     bus  sprite_motion_if.slave (buttons, scan position, ROM data in;
//          position, facing, ROM address, rgb, background out)
//   Pixel timing: rom_row/rom_col lag hCount/vCount by 1 cycle, rgb lags by
//   2 cycles; sprite_color is expected one cycle after the ROM address.
//   Build option: define SPRITE_MOTION_RAMP_EN to enable the IDLE/SLOW/FAST
//   speed ramp; without it every move is SPEED_MIN pixels.
module sprite_motion_ctrl #(
    parameter int          SPRITE_W    = 30,
    parameter int          SPRITE_H    = 30,
    parameter int          X_MIN       = 144,
    parameter int          X_MAX       = 783,
    parameter int          Y_MIN       = 35,
    parameter int          Y_MAX       = 515,
    parameter int          X_RESET     = 450,
    parameter int          Y_RESET     = 250,
    parameter int          SPEED_MIN   = 2,
    parameter int          SPEED_MAX   = 6,
    parameter int          RAMP_TICKS  = 16,
    parameter int          WRAP        = 1,
    parameter logic [11:0] TRANSPARENT = 12'h4F0
) (
    input  logic           clk,
    input  logic           rst,
    sprite_motion_if.slave bus
);

    localparam int XL = X_MAX - SPRITE_W + 1;
    localparam int YL = Y_MAX - SPRITE_H + 1;

    localparam logic signed [10:0] X_LO   = 11'(X_MIN);
    localparam logic signed [10:0] X_HI   = 11'(XL);
    localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
    localparam logic signed [10:0] Y_HI   = 11'(YL);
    localparam logic signed [10:0] W_LAST = 11'(SPRITE_W - 1);
    localparam logic signed [10:0] H_LAST = 11'(SPRITE_H - 1);

    // Brings a candidate position back into [lo, hi]: jump to the opposite
    // edge when wrapping, otherwise saturate.
    function automatic logic [9:0] fit_axis(input logic signed [10:0] pos,
                                            input logic signed [10:0] lo,
                                            input logic signed [10:0] hi);
        logic [9:0] r;
        if (pos > hi)
            r = (WRAP != 0) ? lo[9:0] : hi[9:0];
        else if (pos < lo)
            r = (WRAP != 0) ? hi[9:0] : lo[9:0];
        else
            r = pos[9:0];
        return r;
    endfunction

    logic [9:0]         xpos_r;
    logic [9:0]         ypos_r;
    logic               facing_r;
    logic [11:0]        bg_r;
    logic               pressed;
    logic signed [10:0] step;
    logic signed [10:0] x_sum;
    logic signed [10:0] y_sum;

    assign pressed = bus.up | bus.down | bus.left | bus.right;

`ifdef SPRITE_MOTION_RAMP_EN
    localparam int HC_W = $clog2(RAMP_TICKS) + 1;

    typedef enum logic [1:0] {IDLE, SLOW, FAST} step_state_t;

    step_state_t     state;
    logic [HC_W-1:0] hc;

    // hc counts the ticks of the current press, the first one included, so
    // the press switches to FAST after RAMP_TICKS ticks at SPEED_MIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hc    <= '0;
        end else if (bus.move_tick) begin
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= SLOW;
                        hc    <= HC_W'(1);
                    end
                end
                SLOW: begin
                    if (!pressed) begin
                        state <= IDLE;
                        hc    <= '0;
                    end else begin
                        hc <= hc + 1'b1;
                        if (hc == HC_W'(RAMP_TICKS - 1))
                            state <= FAST;
                    end
                end
                FAST: begin
                    if (!pressed) begin
                        state <= IDLE;
                        hc    <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    hc    <= '0;
                end
            endcase
        end
    end

    // The state before the tick selects the step; IDLE covers the first
    // tick of a press, which moves at SPEED_MIN.
    assign step = (state == FAST) ? 11'(SPEED_MAX) : 11'(SPEED_MIN);
`else
    assign step = 11'(SPEED_MIN);
`endif

    // Opposite buttons on one axis cancel; signed 11-bit sums keep
    // below-zero candidates visible to fit_axis.
    always_comb begin
        x_sum = $signed({1'b0, xpos_r});
        y_sum = $signed({1'b0, ypos_r});
        if (bus.right && !bus.left)
            x_sum = x_sum + step;
        else if (bus.left && !bus.right)
            x_sum = x_sum - step;
        if (bus.down && !bus.up)
            y_sum = y_sum + step;
        else if (bus.up && !bus.down)
            y_sum = y_sum - step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xpos_r   <= 10'(X_RESET);
            ypos_r   <= 10'(Y_RESET);
            facing_r <= 1'b0;
        end else if (bus.move_tick) begin
            xpos_r <= fit_axis(x_sum, X_LO, X_HI);
            ypos_r <= fit_axis(y_sum, Y_LO, Y_HI);
            if (bus.left && !bus.right)
                facing_r <= 1'b1;
            else if (bus.right && !bus.left)
                facing_r <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bg_r <= 12'hFFF;
        else if (bus.right)
            bg_r <= 12'hFF0;
        else if (bus.left)
            bg_r <= 12'h0FF;
        else if (bus.down)
            bg_r <= 12'h0F0;
        else if (bus.up)
            bg_r <= 12'h00F;
    end

    logic signed [10:0] h_off;
    logic signed [10:0] v_off;
    logic               fill_p1;
    logic               bright_p1;
    logic [9:0]         rom_row_p1;
    logic [9:0]         rom_col_p1;
    logic               fill_p2;
    logic               bright_p2;

    assign h_off = $signed({1'b0, bus.hCount}) - $signed({1'b0, xpos_r});
    assign v_off = $signed({1'b0, bus.vCount}) - $signed({1'b0, ypos_r});

    // Stage 1: sprite hit test and (mirrored) ROM address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_p1    <= 1'b0;
            bright_p1  <= 1'b0;
            rom_row_p1 <= '0;
            rom_col_p1 <= '0;
        end else begin
            fill_p1    <= !h_off[10] && (h_off <= W_LAST) && !v_off[10] && (v_off <= H_LAST);
            bright_p1  <= bus.bright;
            rom_row_p1 <= v_off[9:0];
            rom_col_p1 <= facing_r ? (W_LAST[9:0] - h_off[9:0]) : h_off[9:0];
        end
    end

    // Stage 2: flags aligned with the ROM data returned for the stage 1 address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_p2   <= 1'b0;
            bright_p2 <= 1'b0;
        end else begin
            fill_p2   <= fill_p1;
            bright_p2 <= bright_p1;
        end
    end

    assign bus.rgb = !bright_p2 ? 12'h000 :
                     (fill_p2 && (bus.sprite_color != TRANSPARENT)) ? bus.sprite_color : bg_r;

    assign bus.rom_row     = rom_row_p1;
    assign bus.rom_col     = rom_col_p1;
    assign bus.xpos        = xpos_r;
    assign bus.ypos        = ypos_r;
    assign bus.facing_left = facing_r;
    assign bus.background  = bg_r;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl
//   Bench for sprite_motion_ctrl. Three instances share clk/rst and the
//   scan inputs: A uses default parameters, B starts at the left edge
//   (X_RESET=144, wrap), C starts just below the top edge (Y_RESET=36,
//   clamp). Expected positions and pixels are computed by a small model and
//   queued when stimulus is driven, then popped when the DUT output is due.
module tb_sprite_motion_ctrl;

`ifdef SPRITE_MOTION_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    localparam int XLO = 144;
    localparam int XHI = 754;
    localparam int YLO = 35;
    localparam int YHI = 486;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        mt [3];
    logic        bu [3];
    logic        bd [3];
    logic        bl [3];
    logic        br [3];
    logic        bright;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [11:0] scol;

    logic [9:0]  xo [3];
    logic [9:0]  yo [3];
    logic        fo [3];

    sprite_motion_if if_a ();
    sprite_motion_if if_b ();
    sprite_motion_if if_c ();

    sprite_motion_ctrl u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    sprite_motion_ctrl #(.X_RESET(144)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    sprite_motion_ctrl #(.Y_RESET(36), .WRAP(0)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    assign if_a.move_tick = mt[0]; assign if_a.up = bu[0]; assign if_a.down = bd[0];
    assign if_a.left = bl[0]; assign if_a.right = br[0]; assign if_a.bright = bright;
    assign if_a.hCount = hcount; assign if_a.vCount = vcount; assign if_a.sprite_color = scol;
    assign if_b.move_tick = mt[1]; assign if_b.up = bu[1]; assign if_b.down = bd[1];
    assign if_b.left = bl[1]; assign if_b.right = br[1]; assign if_b.bright = bright;
    assign if_b.hCount = hcount; assign if_b.vCount = vcount; assign if_b.sprite_color = scol;
    assign if_c.move_tick = mt[2]; assign if_c.up = bu[2]; assign if_c.down = bd[2];
    assign if_c.left = bl[2]; assign if_c.right = br[2]; assign if_c.bright = bright;
    assign if_c.hCount = hcount; assign if_c.vCount = vcount; assign if_c.sprite_color = scol;

    assign xo[0] = if_a.xpos; assign yo[0] = if_a.ypos; assign fo[0] = if_a.facing_left;
    assign xo[1] = if_b.xpos; assign yo[1] = if_b.ypos; assign fo[1] = if_b.facing_left;
    assign xo[2] = if_c.xpos; assign yo[2] = if_c.ypos; assign fo[2] = if_c.facing_left;

    int checks = 0;
    int errors = 0;

    // Model state per instance.
    int mx [3];
    int my [3];
    bit mf [3];
    int held [3];
    bit mwrap [3] = '{1'b1, 1'b1, 1'b0};

    typedef struct {
        int x;
        int y;
        bit f;
    } mot_t;
    mot_t mot_q [$];

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        b;
        logic [11:0] sc;
    } pix_t;
    logic [19:0] rom_q [$];
    logic [11:0] rgb_q [$];

    function automatic int axis(input int cur, input int dir, input int step,
                                input int lo, input int hi, input bit wrap);
        int n;
        if (dir == 0) return cur;
        n = cur + dir * step;
        if (n > hi) return wrap ? lo : hi;
        if (n < lo) return wrap ? hi : lo;
        return n;
    endfunction

    function automatic logic [11:0] bg_pick(input logic u, input logic d, input logic l,
                                            input logic r, input logic [11:0] prev);
        if (r) return 12'hFF0;
        if (l) return 12'h0FF;
        if (d) return 12'h0F0;
        if (u) return 12'h00F;
        return prev;
    endfunction

    task automatic model_reset();
        mx = '{450, 144, 450};
        my = '{250, 250, 36};
        mf = '{1'b0, 1'b0, 1'b0};
        held = '{0, 0, 0};
    endtask

    // One move_tick on instance k with the given buttons held.
    task automatic tick(input int k, input bit uu, input bit dd, input bit ll, input bit rr);
        mot_t e;
        int   step;
        @(negedge clk);
        bu[k] = uu; bd[k] = dd; bl[k] = ll; br[k] = rr;
        mt[k] = 1'b1;
        if (uu | dd | ll | rr) begin
            step = (RAMP_ON && held[k] >= 16) ? 6 : 2;
            held[k]++;
            mx[k] = axis(mx[k], int'(rr) - int'(ll), step, XLO, XHI, mwrap[k]);
            my[k] = axis(my[k], int'(dd) - int'(uu), step, YLO, YHI, mwrap[k]);
            if (ll && !rr) mf[k] = 1'b1;
            else if (rr && !ll) mf[k] = 1'b0;
        end else begin
            held[k] = 0;
        end
        e.x = mx[k]; e.y = my[k]; e.f = mf[k];
        mot_q.push_back(e);
        @(negedge clk);
        mt[k] = 1'b0;
        e = mot_q.pop_front();
        checks++;
        if (xo[k] !== 10'(e.x)) begin
            errors++;
            $display("FAIL tick_xpos inst%0d got %0d expected %0d", k, xo[k], e.x);
        end
        checks++;
        if (yo[k] !== 10'(e.y)) begin
            errors++;
            $display("FAIL tick_ypos inst%0d got %0d expected %0d", k, yo[k], e.y);
        end
        checks++;
        if (fo[k] !== e.f) begin
            errors++;
            $display("FAIL tick_facing inst%0d got %0b expected %0b", k, fo[k], e.f);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bright = 1'b0; hcount = '0; vcount = '0; scol = '0;
        for (int i = 0; i < 3; i++) begin
            mt[i] = 0; bu[i] = 0; bd[i] = 0; bl[i] = 0; br[i] = 0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (if_a.xpos !== 10'd450 || if_a.ypos !== 10'd250 || if_a.facing_left !== 1'b0) begin
            errors++;
            $display("FAIL reset_pos got %0d,%0d,%0b expected 450,250,0",
                     if_a.xpos, if_a.ypos, if_a.facing_left);
        end
        checks++;
        if (if_a.background !== 12'hFFF) begin
            errors++;
            $display("FAIL reset_bg got %h expected fff", if_a.background);
        end
        checks++;
        if (if_a.rgb !== 12'h000 || if_a.rom_row !== 10'd0 || if_a.rom_col !== 10'd0) begin
            errors++;
            $display("FAIL reset_pix got rgb %h row %0d col %0d expected 0", if_a.rgb,
                     if_a.rom_row, if_a.rom_col);
        end
        checks++;
        if (if_b.xpos !== 10'd144 || if_c.ypos !== 10'd36) begin
            errors++;
            $display("FAIL reset_param got %0d,%0d expected 144,36", if_b.xpos, if_c.ypos);
        end
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 0, 1);
        checks++;
        if (if_a.xpos !== (RAMP_ON ? 10'd506 : 10'd490)) begin
            errors++;
            $display("FAIL ramp_final got %0d expected %0d", if_a.xpos, RAMP_ON ? 506 : 490);
        end
        checks++;
        if (if_a.background !== 12'hFF0) begin
            errors++;
            $display("FAIL ramp_bg got %h expected ff0", if_a.background);
        end
    endtask

    task automatic test_background();
        logic [3:0]  pat [6];
        logic [11:0] exp_bg;
        pat = '{4'b0100, 4'b1100, 4'b1000, 4'b1110, 4'b0011, 4'b0000};
        exp_bg = 12'hFF0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            {bu[0], bd[0], bl[0], br[0]} = pat[i];
            exp_bg = bg_pick(pat[i][3], pat[i][2], pat[i][1], pat[i][0], exp_bg);
            @(negedge clk);
            checks++;
            if (if_a.background !== exp_bg) begin
                errors++;
                $display("FAIL bg_prio pat %b got %h expected %h", pat[i], if_a.background, exp_bg);
            end
        end
    endtask

    task automatic test_diagonal();
        tick(0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 1);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 1);
        tick(0, 0, 1, 0, 0);
    endtask

    task automatic test_pixel();
        pix_t        pv [6];
        pix_t        p;
        logic [19:0] er;
        logic [11:0] eg;
        logic [11:0] bgx;
        int          ho, vo, col;
        bit          fill;
        pv[0] = '{10'd754, 10'd253, 1'b1, 12'h4F0};
        pv[1] = '{10'd754, 10'd253, 1'b1, 12'hF00};
        pv[2] = '{10'd783, 10'd279, 1'b1, 12'h123};
        pv[3] = '{10'd753, 10'd260, 1'b1, 12'hF00};
        pv[4] = '{10'd760, 10'd260, 1'b0, 12'hF00};
        pv[5] = '{10'd760, 10'd249, 1'b1, 12'hABC};
        bgx = bg_pick(bu[1], bd[1], bl[1], br[1], 12'h0FF);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 6) begin
                er = rom_q.pop_front();
                checks++;
                if ({if_b.rom_row, if_b.rom_col} !== er) begin
                    errors++;
                    $display("FAIL pix_rom vec%0d got row %0d col %0d expected row %0d col %0d",
                             i - 1, if_b.rom_row, if_b.rom_col, er[19:10], er[9:0]);
                end
            end
            if (i >= 2) scol = pv[i-2].sc;
            if (i < 6) begin
                p = pv[i];
                hcount = p.h; vcount = p.v; bright = p.b;
                ho = int'(p.h) - mx[1];
                vo = int'(p.v) - my[1];
                col = mf[1] ? (29 - ho) : ho;
                rom_q.push_back({10'(vo), 10'(col)});
                fill = (ho >= 0) && (ho <= 29) && (vo >= 0) && (vo <= 29);
                rgb_q.push_back(!p.b ? 12'h000 : (fill && p.sc != 12'h4F0) ? p.sc : bgx);
            end else begin
                bright = 1'b0;
            end
            #1;
            if (i >= 2) begin
                eg = rgb_q.pop_front();
                checks++;
                if (if_b.rgb !== eg) begin
                    errors++;
                    $display("FAIL pix_rgb vec%0d got %h expected %h", i - 2, if_b.rgb, eg);
                end
            end
        end
    endtask

    task automatic test_wrap();
        tick(1, 0, 0, 1, 0);
        test_pixel();
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 1);
        checks++;
        if (if_b.xpos !== 10'd144) begin
            errors++;
            $display("FAIL wrap_right got %0d expected 144", if_b.xpos);
        end
    endtask

    task automatic test_clamp();
        tick(2, 1, 0, 0, 0);
        tick(2, 1, 0, 0, 0);
        checks++;
        if (if_c.ypos !== 10'd35) begin
            errors++;
            $display("FAIL clamp_top got %0d expected 35", if_c.ypos);
        end
    endtask

    task automatic test_reset_midramp();
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (if_a.xpos !== 10'd450 || if_a.facing_left !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %0d,%0b expected 450,0", if_a.xpos, if_a.facing_left);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ramp();
        test_background();
        test_diagonal();
        test_wrap();
        test_clamp();
        test_reset_midramp();
        if (mot_q.size() != 0 || rom_q.size() != 0 || rgb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover mot %0d rom %0d rgb %0d expected 0",
                     mot_q.size(), rom_q.size(), rgb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
